// File: rtl/inst_aligner.sv
// inst_aligner: fetch-side instruction aligner for an RV32IC core.
//
// Fetches word-aligned 32-bit words from instruction memory into a
// three-halfword queue and presents one complete instruction per cycle to
// the decoder. The instruction is either 16-bit compressed or 32-bit; a
// 32-bit instruction may straddle a word boundary. The aligner also tracks
// the PC of the presented instruction and restarts on a redirect (flush).
//
// Ports:
//   clk, rst_n      core clock, asynchronous active-low reset
//   imem_req        registered one-cycle fetch request pulse
//   imem_addr       registered word address of the request ([1:0] = 0)
//   imem_rvalid     one-cycle response pulse for the outstanding request
//   imem_rdata      response word, halfword 0 in [15:0]
//   flush           redirect; overrides every other update this cycle
//   flush_pc        halfword-aligned redirect target
//   inst_ready      decoder accepts the presented instruction
//   inst_valid      inst / inst_pc / is_compressed are valid
//   inst            instruction; compressed ones are zero-extended
//   inst_pc         PC of inst
//   is_compressed   inst[1:0] != 2'b11
//
// Handshakes: an instruction transfers on a cycle where inst_valid and
// inst_ready are both high; inst_valid never depends on inst_ready. Memory
// has at most one request in flight; imem_rvalid answers it exactly once.

module inst_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        inst_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        is_compressed
);

    logic [2:0][15:0] q;          // q[0] is the head halfword
    logic [2:0][15:0] q_nxt;
    logic [1:0]       count;
    logic [1:0]       count_nxt;
    logic [31:0]      fetch_addr;
    logic [31:0]      head_pc;
    logic             outstanding;
    logic             drop_resp;  // the in-flight response belongs to a flushed stream
    logic             skip_low;   // next accepted word starts at its upper halfword

    logic             head_comp;
    logic             head_full;
    logic             consume;
    logic             resp;
    logic             issue;
    logic [1:0]       shift;

    // Head decode and handshake. Outputs come from the queue registers only;
    // imem_rdata has no combinational path to inst.
    always_comb begin
        head_comp     = (q[0][1:0] != 2'b11);
        head_full     = head_comp ? (count >= 2'd1) : (count >= 2'd2);
        inst_valid    = head_full && !flush;
        consume       = inst_valid && inst_ready;
        // A response with nothing requested (e.g. straight after reset) is ignored.
        resp          = imem_rvalid && outstanding;
        // Requesting only at count<=1 leaves room for both halfwords of the reply.
        issue         = !outstanding && !drop_resp && (count <= 2'd1) && !flush;
        shift         = consume ? (head_comp ? 2'd1 : 2'd2) : 2'd0;
        is_compressed = (count != 2'd0) && head_comp;
        inst          = '0;
        if (count != 2'd0) begin
            inst = head_comp ? {16'h0000, q[0]} : {q[1], q[0]};
        end
    end

    // Queue update: consume first, then append the response behind what is left.
    always_comb begin
        q_nxt     = q;
        count_nxt = count - shift;
        case (shift)
            2'd1:    q_nxt = {16'h0000, q[2], q[1]};
            2'd2:    q_nxt = {16'h0000, 16'h0000, q[2]};
            default: q_nxt = q;
        endcase
        if (resp && !drop_resp) begin
            for (int i = 0; i < 3; i++) begin
                if (i == int'(count_nxt)) begin
                    q_nxt[i] = skip_low ? imem_rdata[31:16] : imem_rdata[15:0];
                end else if (!skip_low && (i == int'(count_nxt) + 1)) begin
                    q_nxt[i] = imem_rdata[31:16];
                end
            end
            count_nxt = count_nxt + (skip_low ? 2'd1 : 2'd2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q           <= '0;
            count       <= 2'd0;
            fetch_addr  <= {RESET_PC[31:2], 2'b00};
            head_pc     <= RESET_PC;
            outstanding <= 1'b0;
            drop_resp   <= 1'b0;
            skip_low    <= RESET_PC[1];
            imem_req    <= 1'b0;
            imem_addr   <= 32'h0000_0000;
        end else begin
            // The memory transaction completes regardless of a flush.
            if (issue) begin
                outstanding <= 1'b1;
            end else if (resp) begin
                outstanding <= 1'b0;
            end
            imem_req <= issue;
            if (issue) begin
                imem_addr <= fetch_addr;
            end

            if (flush) begin
                count      <= 2'd0;
                head_pc    <= flush_pc;
                fetch_addr <= {flush_pc[31:2], 2'b00};
                skip_low   <= flush_pc[1];
                // A reply still to come belongs to the old stream; one arriving
                // this cycle is simply not appended.
                drop_resp  <= outstanding && !imem_rvalid;
            end else begin
                q     <= q_nxt;
                count <= count_nxt;
                if (consume) begin
                    head_pc <= head_pc + (head_comp ? 32'd2 : 32'd4);
                end
                if (issue) begin
                    fetch_addr <= fetch_addr + 32'd4;
                end
                if (resp) begin
                    drop_resp <= 1'b0;
                    if (!drop_resp) begin
                        skip_low <= 1'b0;
                    end
                end
            end
        end
    end

    assign inst_pc = head_pc;

endmodule
